spi_frame_rx: RTL



---
 rtl/spi_frame_pkg.sv | 28 ++
 rtl/spi_frame_rx_sync.sv | 30 +++
 rtl/spi_frame_rx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_pkg.sv
// Shared constants, state encoding and helpers for the SPI receive framer.
package spi_frame_pkg;

    localparam int unsigned WORD_W          = 16;
    localparam int unsigned DATA_W          = 14;
    localparam int unsigned WORDS_PER_FRAME = 4;
    localparam logic [15:0] HEADER          = 16'hA55A;

    localparam int unsigned WORD_CNT_W = $clog2(WORDS_PER_FRAME);
    typedef logic [WORD_CNT_W-1:0] word_idx_t;

    localparam word_idx_t WORD_S2  = word_idx_t'(1);
    localparam word_idx_t WORD_S3  = word_idx_t'(2);
    localparam word_idx_t WORD_REF = word_idx_t'(WORDS_PER_FRAME - 1);

    typedef enum logic [2:0] {
        WAIT_CS,
        IDLE,
        HDR,
        DATA,
        DRAIN
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_frame_rx_sync.sv
// Multi-flop synchroniser for one asynchronous input, plus a registered copy for edge detection.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI-slave receive framer: deserialises MSB-first words, validates a 4-word frame and
// presents three operands to the core with a one-cycle head_flag strobe.
module spi_frame_rx #(
    parameter int unsigned       SYNC_STAGES = 2,
    parameter int unsigned       WORD_W      = spi_frame_pkg::WORD_W,
    parameter int unsigned       DATA_W      = spi_frame_pkg::DATA_W,
    parameter logic [WORD_W-1:0] HEADER      = spi_frame_pkg::HEADER
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sck,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] buffer_2,
    output logic [DATA_W-1:0] buffer_3,
    output logic [DATA_W-1:0] reff,
    output logic              head_flag,
    output logic              frame_err,
    output logic [7:0]        err_cnt
);

    import spi_frame_pkg::*;

    localparam int unsigned         BIT_CNT_W = $clog2(WORD_W);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(WORD_W - 1);

    logic w_sck_lvl, w_sck_rise, w_sck_fall;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_d     (sck),
        .o_level (w_sck_lvl),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_d     (cs),
        .o_level (w_cs_lvl),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_d     (mosi),
        .o_level (w_mosi_lvl),
        .o_rise  (w_mosi_rise),
        .o_fall  (w_mosi_fall)
    );

    assign w_unused = &{w_sck_lvl, w_sck_fall, w_mosi_rise, w_mosi_fall, 1'b0};

    // Deserialiser
    logic [WORD_W-1:0]    r_shift;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic                 r_word_vld;
    logic                 r_cs_rise_d;
    logic                 w_take_bit;

    // A bit arriving together with cs release still belongs to the frame.
    assign w_take_bit = w_sck_rise && (!w_cs_lvl || w_cs_rise);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_word_vld  <= 1'b0;
            r_cs_rise_d <= 1'b0;
        end else begin
            r_word_vld  <= 1'b0;
            r_cs_rise_d <= w_cs_rise;
            if (w_cs_fall) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if (w_take_bit) begin
                r_shift <= {r_shift[WORD_W-2:0], w_mosi_lvl};
                if (r_bit_cnt == BIT_LAST) begin
                    r_bit_cnt  <= '0;
                    r_word_vld <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                end
            end
        end
    end

    // Frame FSM
    state_e            r_state, w_state_nxt;
    word_idx_t         r_word_cnt, w_word_cnt_nxt;
    logic [DATA_W-1:0] r_stg_2, r_stg_3, r_stg_ref;
    logic [DATA_W-1:0] w_stg_2_nxt, w_stg_3_nxt, w_stg_ref_nxt;
    logic              r_commit, w_commit;
    logic              r_frame_err, w_err;
    logic [7:0]        r_err_cnt, w_err_cnt_nxt;
    logic [DATA_W-1:0] w_word_data;

    assign w_word_data = r_shift[DATA_W-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= WAIT_CS;
            r_word_cnt  <= '0;
            r_stg_2     <= '0;
            r_stg_3     <= '0;
            r_stg_ref   <= '0;
            r_commit    <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_stg_2     <= w_stg_2_nxt;
            r_stg_3     <= w_stg_3_nxt;
            r_stg_ref   <= w_stg_ref_nxt;
            r_commit    <= w_commit;
            r_frame_err <= w_err;
            r_err_cnt   <= w_err_cnt_nxt;
        end
    end

    // r_word_vld and r_cs_rise_d are aligned, so a coincident last bit and cs release
    // are seen in the same cycle and the completed word wins.
    always_comb begin
        w_state_nxt    = r_state;
        w_word_cnt_nxt = r_word_cnt;
        w_stg_2_nxt    = r_stg_2;
        w_stg_3_nxt    = r_stg_3;
        w_stg_ref_nxt  = r_stg_ref;
        w_commit       = 1'b0;
        w_err          = 1'b0;
        unique case (r_state)
            WAIT_CS: begin
                if (w_cs_lvl) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt    = HDR;
                    w_word_cnt_nxt = '0;
                end
            end
            HDR: begin
                if (r_word_vld && (r_shift != HEADER)) begin
                    w_err       = 1'b1;
                    w_state_nxt = r_cs_rise_d ? IDLE : DRAIN;
                end else if (r_cs_rise_d) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_word_vld) begin
                    w_state_nxt    = DATA;
                    w_word_cnt_nxt = WORD_S2;
                end
            end
            DATA: begin
                if (r_word_vld && (r_word_cnt == WORD_REF)) begin
                    w_stg_ref_nxt = w_word_data;
                    w_commit      = 1'b1;
                    w_state_nxt   = r_cs_rise_d ? IDLE : DRAIN;
                end else if (r_cs_rise_d) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_word_vld) begin
                    case (r_word_cnt)
                        WORD_S2: w_stg_2_nxt = w_word_data;
                        WORD_S3: w_stg_3_nxt = w_word_data;
                        default: ;
                    endcase
                    w_word_cnt_nxt = r_word_cnt + word_idx_t'(1);
                end
            end
            DRAIN: begin
                if (r_cs_rise_d) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = WAIT_CS;
        endcase
        w_err_cnt_nxt = w_err ? sat_inc8(r_err_cnt) : r_err_cnt;
    end

    // Output holding registers
    logic [DATA_W-1:0] r_buf_2, r_buf_3, r_buf_ref;
    logic              r_head_flag;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf_2     <= '0;
            r_buf_3     <= '0;
            r_buf_ref   <= '0;
            r_head_flag <= 1'b0;
        end else begin
            r_head_flag <= r_commit;
            if (r_commit) begin
                r_buf_2   <= r_stg_2;
                r_buf_3   <= r_stg_3;
                r_buf_ref <= r_stg_ref;
            end
        end
    end

    assign buffer_2  = r_buf_2;
    assign buffer_3  = r_buf_3;
    assign reff      = r_buf_ref;
    assign head_flag = r_head_flag;
    assign frame_err = r_frame_err;
    assign err_cnt   = r_err_cnt;

endmodule
